cdf_row_sched: RTL and testbench
================================

CDF_ROW_SCHED -- requirements
Module: cdf_row_sched

Interface
REQ-001 SHALL have parameter: ROWS, 8, number of image rows per frame (2..255).
REQ-002 SHALL take LENGTH (row width in bytes, even, >=4) from package essentials.
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: start  input  1  begin-frame request, sampled in ST_IDLE only.
REQ-006 SHALL have port: pix_valid  input  1  source byte valid.
REQ-007 SHALL have port: pix_data  input  8  source pixel byte, row-major.
REQ-008 SHALL have port: pix_ready  output  1  scheduler accepts byte this cycle.
REQ-009 SHALL have port: row_out  output  8 x LENGTH  buffered row driven to the CDF row streamer.
REQ-010 SHALL have port: cdf_en  output  1  one-cycle start pulse to the row streamer.
REQ-011 SHALL have port: cdf_result  input  1  row streamer output-valid, high LENGTH/2 cycles per row.
REQ-012 SHALL have port: busy  output  1  high in any state except ST_IDLE.
REQ-013 SHALL have port: row_idx  output  8  index of row being loaded or streamed.
REQ-014 SHALL have port: row_done  output  1  one-cycle pulse, row fully streamed.
REQ-015 SHALL have port: frame_done  output  1  one-cycle pulse, last row fully streamed.

Function
REQ-016 SHALL implement states ST_IDLE, ST_LOAD, ST_START, ST_STREAM, ST_DONE.
REQ-017 SHALL go ST_IDLE -> ST_LOAD when start=1, clearing row_idx and load index to 0; start in other states ignored.
REQ-018 SHALL drive pix_ready=1 only in ST_LOAD; byte accepted when pix_valid&pix_ready, written to row_out[load index], index incremented.
REQ-019 SHALL go ST_LOAD -> ST_START on acceptance of byte LENGTH-1; load index returns to 0.
REQ-020 SHALL assert cdf_en for exactly the single ST_START cycle, then enter ST_STREAM.
REQ-021 SHALL hold row_out unchanged from ST_START until row_done.
REQ-022 SHALL count cdf_result-high cycles in ST_STREAM; on count LENGTH/2 pulse row_done next cycle.
REQ-023 SHALL, at row_done, go to ST_LOAD with row_idx+1 if row_idx<ROWS-1, else to ST_DONE.
REQ-024 SHALL pulse frame_done for the single ST_DONE cycle, then return to ST_IDLE; row_idx holds ROWS-1 until next start.
REQ-025 SHALL ignore cdf_result outside ST_STREAM; never assert cdf_en twice per row.
REQ-026 SHALL, with pix_valid held high, deliver a row every LENGTH+1+LENGTH/2+1 cycles.

Reset
REQ-027 SHALL, on resetn=0 at any time (incl. mid-row), enter ST_IDLE and clear pix_ready, cdf_en, busy, row_idx, row_done, frame_done, result counter, load index, and all row_out bytes to 0.

Configuration
REQ-028 SHALL, with CDF_SCHED_ABORT_EN defined, add input abort (1) and output aborted (1): abort=1 in ST_LOAD/ST_START/ST_STREAM -> ST_IDLE next cycle, aborted pulses one cycle, no row_done/frame_done; abort has priority over same-cycle row completion.
REQ-029 SHALL, without CDF_SCHED_ABORT_EN, omit both ports and abort logic.

Structure
REQ-030 SHALL place LENGTH and the state enum type sched_state_t in package essentials.
REQ-031 SHALL implement the byte-addressed row register as sub-module cdf_row_buf (write enable, 8-bit address, 8-bit data, full-row parallel read).

Verification
REQ-032 SHALL test: reset, start, ROWS=2, LENGTH=8, bytes 0..15 -> row 0 row_out=0..7, one cdf_en, row_done after 4 result cycles; row 1 row_out=8..15; frame_done once.
REQ-033 SHALL test: pix_valid toggled every other cycle -> exactly LENGTH bytes stored in order, pix_ready low during ST_STREAM.
REQ-034 SHALL test: start pulsed while busy -> no effect, row_idx sequence unchanged.
REQ-035 SHALL test: resetn low mid-ST_STREAM -> all outputs 0 next cycle, new start restarts at row_idx=0.
REQ-036 SHALL test (CDF_SCHED_ABORT_EN): abort on 3rd result cycle -> aborted pulse, ST_IDLE, no row_done.
REQ-037 SHALL test: pix_valid held high, ROWS=3, LENGTH=8 -> frame_done 42 cycles after first accepted byte.

Source files
------------

// File: rtl/cdf_row_sched_pkg.sv
// essentials: shared row geometry and scheduler state type for the CDF row scheduler.
package essentials;
    localparam int LENGTH = 8;
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_START, ST_STREAM, ST_DONE} sched_state_t;
endpackage

// File: rtl/cdf_row_sched_if.sv
// cdf_row_sched_if: pixel source, row streamer and status signals of the row scheduler.
interface cdf_row_sched_if;
    import essentials::*;
    logic start, pix_valid, pix_ready, cdf_en, cdf_result, busy, row_done, frame_done;
    logic [7:0] pix_data, row_idx;
    logic [LENGTH-1:0][7:0] row_out;
    modport master (output start, pix_valid, pix_data, cdf_result,
                    input pix_ready, row_out, cdf_en, busy, row_idx, row_done, frame_done);
    modport slave (input start, pix_valid, pix_data, cdf_result,
                   output pix_ready, row_out, cdf_en, busy, row_idx, row_done, frame_done);
endinterface

// File: rtl/cdf_row_sched_buf.sv
// cdf_row_buf: byte-addressed row register with full-row parallel read.
module cdf_row_buf import essentials::*; (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   we,
    input  logic [7:0]             addr,
    input  logic [7:0]             data,
    output logic [LENGTH-1:0][7:0] row
);
    localparam int AW = $clog2(LENGTH);
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) row <= '0;
        else if (we) row[addr[AW-1:0]] <= data;
endmodule

// File: rtl/cdf_row_sched.sv
// cdf_row_sched: loads image rows byte by byte and hands each to the CDF row streamer.
// Optional abort input/aborted pulse enabled by defining CDF_SCHED_ABORT_EN.
module cdf_row_sched import essentials::*; #(
    parameter int ROWS = 8
) (
    input  logic clk,
    input  logic resetn,
`ifdef CDF_SCHED_ABORT_EN
    input  logic abort,
    output logic aborted,
`endif
    cdf_row_sched_if.slave sif
);
    localparam logic [7:0] LAST_BYTE = 8'(LENGTH - 1);
    localparam logic [7:0] HALF_LAST = 8'(LENGTH / 2 - 1);
    localparam logic [7:0] LAST_ROW  = 8'(ROWS - 1);
    sched_state_t state;
    logic [7:0] load_idx, res_cnt;
    logic we, ab;
    assign we = state == ST_LOAD && sif.pix_valid && sif.pix_ready;
`ifdef CDF_SCHED_ABORT_EN
    assign ab = abort && (state == ST_LOAD || state == ST_START || state == ST_STREAM);
`else
    assign ab = 1'b0;
`endif
    cdf_row_buf u_buf (.clk(clk), .resetn(resetn), .we(we), .addr(load_idx), .data(sif.pix_data), .row(sif.row_out));
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= ST_IDLE;
            sif.pix_ready  <= 1'b0;
            sif.cdf_en     <= 1'b0;
            sif.busy       <= 1'b0;
            sif.row_idx    <= '0;
            sif.row_done   <= 1'b0;
            sif.frame_done <= 1'b0;
            res_cnt        <= '0;
            load_idx       <= '0;
`ifdef CDF_SCHED_ABORT_EN
            aborted        <= 1'b0;
`endif
        end else begin
            sif.cdf_en     <= 1'b0;
            sif.row_done   <= 1'b0;
            sif.frame_done <= 1'b0;
`ifdef CDF_SCHED_ABORT_EN
            aborted        <= ab;
`endif
            if (ab) begin
                state         <= ST_IDLE;
                sif.pix_ready <= 1'b0;
                sif.busy      <= 1'b0;
                res_cnt       <= '0;
                load_idx      <= '0;
            end else begin
                case (state)
                    ST_IDLE: if (sif.start) begin
                        state         <= ST_LOAD;
                        sif.pix_ready <= 1'b1;
                        sif.busy      <= 1'b1;
                        sif.row_idx   <= '0;
                        load_idx      <= '0;
                    end
                    ST_LOAD: if (we) begin
                        if (load_idx == LAST_BYTE) begin
                            state         <= ST_START;
                            sif.pix_ready <= 1'b0;
                            sif.cdf_en    <= 1'b1;
                            load_idx      <= '0;
                        end else load_idx <= load_idx + 8'd1;
                    end
                    ST_START: state <= ST_STREAM;
                    // row_done is already high here: results in this cycle belong to no row
                    ST_STREAM: if (sif.row_done) begin
                        res_cnt <= '0;
                        if (sif.row_idx == LAST_ROW) begin
                            state          <= ST_DONE;
                            sif.frame_done <= 1'b1;
                        end else begin
                            state         <= ST_LOAD;
                            sif.pix_ready <= 1'b1;
                            sif.row_idx   <= sif.row_idx + 8'd1;
                        end
                    end else if (sif.cdf_result) begin
                        res_cnt      <= res_cnt + 8'd1;
                        sif.row_done <= res_cnt == HALF_LAST;
                    end
                    ST_DONE: begin
                        state    <= ST_IDLE;
                        sif.busy <= 1'b0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cdf_row_sched.sv
// tb_cdf_row_sched: directed tests of the CDF row scheduler with a modelled row streamer.
module tb_cdf_row_sched;
    import essentials::*;
    logic clk = 1'b0, resetn = 1'b0;
    logic s2_res = 1'b0, m2_res = 1'b0, s3_res = 1'b0, auto2 = 1'b1;
    int total = 0, bad = 0;
    cdf_row_sched_if i2();
    cdf_row_sched_if i3();
    assign i2.cdf_result = s2_res | m2_res;
    assign i3.cdf_result = s3_res;
`ifdef CDF_SCHED_ABORT_EN
    logic abort2 = 1'b0, abort3 = 1'b0;
    logic aborted2, aborted3;
`endif
    cdf_row_sched #(.ROWS(2)) u2 (
        .clk(clk), .resetn(resetn),
`ifdef CDF_SCHED_ABORT_EN
        .abort(abort2), .aborted(aborted2),
`endif
        .sif(i2)
    );
    cdf_row_sched #(.ROWS(3)) u3 (
        .clk(clk), .resetn(resetn),
`ifdef CDF_SCHED_ABORT_EN
        .abort(abort3), .aborted(aborted3),
`endif
        .sif(i3)
    );
    always #5 clk = ~clk;

    // streamer model: result high LENGTH/2 cycles, starting the cycle after cdf_en
    initial forever begin
        @(negedge clk);
        if (i2.cdf_en && auto2) begin
            @(negedge clk); s2_res = 1'b1;
            repeat (LENGTH / 2) @(negedge clk);
            s2_res = 1'b0;
        end
    end
    initial forever begin
        @(negedge clk);
        if (i3.cdf_en) begin
            @(negedge clk); s3_res = 1'b1;
            repeat (LENGTH / 2) @(negedge clk);
            s3_res = 1'b0;
        end
    end

    logic [LENGTH-1:0][7:0] exp_row[2];
    logic [LENGTH-1:0][7:0] snap[2];
    logic [7:0] ridx[2];
    int lat[2];
    int nb, n_en, n_rd, n_fd, rdy_strm, t_en;
    bit tmo, strm;

    // runs one frame on the ROWS=2 instance and records what it observes
    task frame(input bit tog, input bit poke, input int stop_en);
        nb = 0; n_en = 0; n_rd = 0; n_fd = 0; rdy_strm = 0; t_en = 0; tmo = 1; strm = 0;
        @(negedge clk); i2.start = 1'b1;
        @(negedge clk); i2.start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (i2.cdf_en) begin n_en++; t_en = c; strm = 1; end
            if (strm && i2.pix_ready) rdy_strm++;
            if (i2.row_done) begin
                if (n_rd < 2) begin snap[n_rd] = i2.row_out; ridx[n_rd] = i2.row_idx; lat[n_rd] = c - t_en; end
                n_rd++; strm = 0;
            end
            if (i2.frame_done) n_fd++;
            if (poke) i2.start = (c % 5 == 2);
            if (i2.frame_done || (stop_en > 0 && n_en == stop_en)) begin tmo = 0; break; end
            i2.pix_valid = tog ? c[0] : 1'b1;
            i2.pix_data = 8'(nb);
            if (i2.pix_valid && i2.pix_ready) nb++;
            @(negedge clk);
        end
        i2.pix_valid = 1'b0; i2.start = 1'b0;
    endtask

    task test_reset;
        repeat (2) @(negedge clk);
        total++; if (i2.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", i2.busy); end
        total++; if (i2.pix_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", i2.pix_ready); end
        total++; if (i2.row_idx !== 8'd0) begin bad++; $display("FAIL rst_row_idx got=%0d want=0", i2.row_idx); end
        total++; if (i2.row_out !== '0) begin bad++; $display("FAIL rst_row_out got=%h want=0", i2.row_out); end
        total++; if ({i2.cdf_en, i2.row_done, i2.frame_done} !== 3'b000) begin bad++; $display("FAIL rst_pulses got=%b want=000", {i2.cdf_en, i2.row_done, i2.frame_done}); end
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (i2.busy !== 1'b0 || i3.busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b%b want=00", i2.busy, i3.busy); end
    endtask

    task test_basic;
        frame(0, 0, 0);
        total++; if (tmo) begin bad++; $display("FAIL basic_timeout got=1 want=0"); end
        total++; if (snap[0] !== exp_row[0]) begin bad++; $display("FAIL basic_row0 got=%h want=%h", snap[0], exp_row[0]); end
        total++; if (snap[1] !== exp_row[1]) begin bad++; $display("FAIL basic_row1 got=%h want=%h", snap[1], exp_row[1]); end
        total++; if (ridx[0] !== 8'd0 || ridx[1] !== 8'd1) begin bad++; $display("FAIL basic_ridx got=%0d,%0d want=0,1", ridx[0], ridx[1]); end
        total++; if (n_en !== 2) begin bad++; $display("FAIL basic_cdf_en got=%0d want=2", n_en); end
        total++; if (n_rd !== 2 || n_fd !== 1) begin bad++; $display("FAIL basic_done_cnt got=%0d,%0d want=2,1", n_rd, n_fd); end
        total++; if (lat[0] !== 5 || lat[1] !== 5) begin bad++; $display("FAIL basic_latency got=%0d,%0d want=5,5", lat[0], lat[1]); end
        total++; if (nb !== 2 * LENGTH) begin bad++; $display("FAIL basic_bytes got=%0d want=%0d", nb, 2 * LENGTH); end
        @(negedge clk);
        total++; if (i2.busy !== 1'b0 || i2.row_idx !== 8'd1) begin bad++; $display("FAIL basic_after got=busy%b idx%0d want=busy0 idx1", i2.busy, i2.row_idx); end
    endtask

    task test_toggle;
        frame(1, 0, 0);
        total++; if (tmo) begin bad++; $display("FAIL toggle_timeout got=1 want=0"); end
        total++; if (snap[0] !== exp_row[0] || snap[1] !== exp_row[1]) begin bad++; $display("FAIL toggle_rows got=%h,%h want=%h,%h", snap[0], snap[1], exp_row[0], exp_row[1]); end
        total++; if (nb !== 2 * LENGTH) begin bad++; $display("FAIL toggle_bytes got=%0d want=%0d", nb, 2 * LENGTH); end
        total++; if (rdy_strm !== 0) begin bad++; $display("FAIL toggle_ready_in_stream got=%0d want=0", rdy_strm); end
    endtask

    task test_start_busy;
        frame(0, 1, 0);
        total++; if (ridx[0] !== 8'd0 || ridx[1] !== 8'd1) begin bad++; $display("FAIL sbusy_ridx got=%0d,%0d want=0,1", ridx[0], ridx[1]); end
        total++; if (n_en !== 2 || n_rd !== 2 || n_fd !== 1) begin bad++; $display("FAIL sbusy_counts got=%0d,%0d,%0d want=2,2,1", n_en, n_rd, n_fd); end
        repeat (3) @(negedge clk);
        total++; if (i2.busy !== 1'b0) begin bad++; $display("FAIL sbusy_idle got=%b want=0", i2.busy); end
    endtask

    task test_reset_mid;
        frame(0, 0, 2);
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        total++; if ({i2.busy, i2.pix_ready, i2.cdf_en, i2.row_done, i2.frame_done} !== 5'b0) begin bad++; $display("FAIL midrst_flags got=%b want=00000", {i2.busy, i2.pix_ready, i2.cdf_en, i2.row_done, i2.frame_done}); end
        total++; if (i2.row_idx !== 8'd0 || i2.row_out !== '0) begin bad++; $display("FAIL midrst_data got=idx%0d row%h want=0", i2.row_idx, i2.row_out); end
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        frame(0, 0, 0);
        total++; if (ridx[0] !== 8'd0 || snap[0] !== exp_row[0] || n_rd !== 2) begin bad++; $display("FAIL midrst_restart got=idx%0d row%h rd%0d want=idx0 row%h rd2", ridx[0], snap[0], n_rd, exp_row[0]); end
    endtask

`ifdef CDF_SCHED_ABORT_EN
    task test_abort;
        auto2 = 1'b0;
        frame(0, 0, 1);
        @(negedge clk); m2_res = 1'b1;
        @(negedge clk);
        @(negedge clk); abort2 = 1'b1;
        @(negedge clk);
        total++; if (aborted2 !== 1'b1 || i2.busy !== 1'b0) begin bad++; $display("FAIL abort_pulse got=ab%b busy%b want=ab1 busy0", aborted2, i2.busy); end
        total++; if (i2.row_done !== 1'b0 || i2.pix_ready !== 1'b0) begin bad++; $display("FAIL abort_outs got=rd%b rdy%b want=0", i2.row_done, i2.pix_ready); end
        abort2 = 1'b0; m2_res = 1'b0;
        @(negedge clk);
        total++; if (aborted2 !== 1'b0 || i2.row_done !== 1'b0 || i2.busy !== 1'b0) begin bad++; $display("FAIL abort_after got=ab%b rd%b busy%b want=000", aborted2, i2.row_done, i2.busy); end
        auto2 = 1'b1;
    endtask
`endif

    task test_back_to_back;
        int t0, t1, nrd;
        int rdt[4];
        t0 = -1; t1 = -1; nrd = 0;
        @(negedge clk); i3.start = 1'b1;
        @(negedge clk); i3.start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (t0 < 0 && i3.pix_ready && i3.pix_valid) t0 = c;
            if (i3.row_done && nrd < 4) begin rdt[nrd] = c; nrd++; end
            if (i3.frame_done) begin t1 = c; break; end
            @(negedge clk);
        end
        total++; if (t1 < 0 || t1 - t0 !== 42) begin bad++; $display("FAIL b2b_frame_latency got=%0d want=42", t1 - t0); end
        total++; if (nrd !== 3) begin bad++; $display("FAIL b2b_rows got=%0d want=3", nrd); end
        total++; if (rdt[0] - t0 !== 13 || rdt[1] - rdt[0] !== 14 || rdt[2] - rdt[1] !== 14) begin bad++; $display("FAIL b2b_row_period got=%0d,%0d,%0d want=13,14,14", rdt[0] - t0, rdt[1] - rdt[0], rdt[2] - rdt[1]); end
    endtask

    initial begin
        for (int k = 0; k < LENGTH; k++) begin
            exp_row[0][k] = 8'(k);
            exp_row[1][k] = 8'(LENGTH + k);
        end
        i2.start = 1'b0; i2.pix_valid = 1'b0; i2.pix_data = '0;
        i3.start = 1'b0; i3.pix_valid = 1'b1; i3.pix_data = 8'hA5;
        test_reset;
        test_basic;
        test_toggle;
        test_start_busy;
        test_reset_mid;
`ifdef CDF_SCHED_ABORT_EN
        test_abort;
`endif
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
